// File: rtl/motor_atuador.sv
// motor_atuador: behavioural model of the gate motor and its limit switches.
// Integrates the controller's drive commands (a = toward fe, b = toward fd)
// into a saturating position counter, decodes the end stops fe/fd from that
// position, and latches a FAULT state on the illegal a=b=1 command.
module motor_atuador #(
    parameter int POS_W     = 4,
    parameter int POS_MAX   = 15,
    parameter int STEP_DIV  = 2,
    parameter int START_POS = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    input  logic             fault_clr,
    output logic             fe,
    output logic             fd,
    output logic [POS_W-1:0] pos,
    output logic             moving,
    output logic             dir,
    output logic             fault
);

    typedef enum logic [1:0] {
        IDLE,
        LEFT,
        RIGHT,
        FAULT
    } state_t;

    localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);
    localparam logic [POS_W-1:0] POS_TOP  = POS_W'(POS_MAX);
    localparam logic [POS_W-1:0] POS_INIT = POS_W'(START_POS);

    state_t           state;
    logic [CNT_W-1:0] cnt;

    // End stops decoded from the registered position only.
    always_comb begin
        fe = (pos == '0);
        fd = (pos == POS_TOP);
    end

    // Motion state machine: state, step divider, position and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            pos    <= POS_INIT;
            cnt    <= '0;
            moving <= 1'b0;
            dir    <= 1'b0;
            fault  <= 1'b0;
        end else if (state == FAULT) begin
            // Position and divider stay frozen until a clean clear request.
            if (fault_clr && !a && !b) begin
                state <= IDLE;
                fault <= 1'b0;
            end
        end else if (a && b) begin
            state  <= FAULT;
            cnt    <= '0;
            moving <= 1'b0;
            dir    <= 1'b0;
            fault  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (a && !fe) begin
                        state  <= LEFT;
                        cnt    <= '0;
                        moving <= 1'b1;
                        dir    <= 1'b0;
                    end else if (b && !fd) begin
                        state  <= RIGHT;
                        cnt    <= '0;
                        moving <= 1'b1;
                        dir    <= 1'b1;
                    end
                end
                LEFT: begin
                    if (a) begin
                        if (cnt == CNT_LAST) begin
                            pos <= pos - 1'b1;
                            cnt <= '0;
                            // Arriving at the stop ends the move on the same edge.
                            if (pos == POS_W'(1)) begin
                                state  <= IDLE;
                                moving <= 1'b0;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else if (b && !fd) begin
                        state <= RIGHT;
                        cnt   <= '0;
                        dir   <= 1'b1;
                    end else begin
                        // Command dropped (or reversal into an active stop):
                        // any partial step is discarded.
                        state  <= IDLE;
                        cnt    <= '0;
                        moving <= 1'b0;
                        dir    <= 1'b0;
                    end
                end
                RIGHT: begin
                    if (b) begin
                        if (cnt == CNT_LAST) begin
                            pos <= pos + 1'b1;
                            cnt <= '0;
                            if (pos == POS_TOP - 1'b1) begin
                                state  <= IDLE;
                                moving <= 1'b0;
                                dir    <= 1'b0;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else if (a && !fe) begin
                        state <= LEFT;
                        cnt   <= '0;
                        dir   <= 1'b0;
                    end else begin
                        state  <= IDLE;
                        cnt    <= '0;
                        moving <= 1'b0;
                        dir    <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
